// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Each grant covers up to MAX_BURST words, and ownership passes to the next requester with no idle cycle.
module sync_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    localparam int OW       = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [OW-1:0]       owner,
    output logic                owner_vld
);

    localparam int            CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] last_q;
    logic [CW-1:0] cnt_q;

    logic          owner_req;
    logic          release_grant;
    logic [OW-1:0] pick_base;
    logic [OW-1:0] pick_idx;
    logic          pick_vld;

    assign owner_vld = (state_q == BURST);
    assign owner     = owner_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        owner_req = 1'b0;
        fifo_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_req = req[i];
                if (owner_vld) fifo_din = req_data[i*DW +: DW];
            end
        end
    end

    assign fifo_wr = owner_vld & owner_req & ~fifo_full;

    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) ack[i] = fifo_wr & (owner_q == OW'(i));
    end

    // During a burst, the releasing owner becomes "last". Its successor therefore starts the search.
    assign pick_base = owner_vld ? owner_q : last_q;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        // Scan from farthest to nearest so the nearest requester is written last and wins.
        for (int k = N_REQ; k >= 1; k--) begin
            automatic int idx = (int'(pick_base) + k) % N_REQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = OW'(idx);
            end
        end
    end

    assign release_grant = owner_vld & (~owner_req | (fifo_wr & (cnt_q == LAST_CNT)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (release_grant) begin
                        last_q <= owner_q;
                        if (pick_vld) begin
                            owner_q <= pick_idx;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (fifo_wr) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Outputs are compared 1 time unit after inputs change. This keeps sampling away from the clock edge.
module tb_sync_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [1:0]  owner;
    logic        owner_vld;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] wc [4];

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic        vld;
        logic [1:0]  own;
        logic        wr;
        logic [3:0]  ack;
        logic [7:0]  din;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle's inputs, compare the outputs, then advance past the next rising edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [31:0] d, input logic f,
                        input logic ev, input logic [1:0] eo, input logic ew,
                        input logic [3:0] ea, input logic [7:0] ed);
        req = r; req_data = d; fifo_full = f;
        #1;
        check({tag, ".owner_vld"}, 32'(owner_vld), 32'(ev));
        if (ev) check({tag, ".owner"}, 32'(owner), 32'(eo));
        check({tag, ".fifo_wr"}, 32'(fifo_wr), 32'(ew));
        check({tag, ".ack"}, 32'(ack), 32'(ea));
        check({tag, ".fifo_din"}, 32'(fifo_din), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) wc[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Requester i always presents {i, words acked so far}.
    function automatic logic [31:0] pk();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = {4'(i), wc[i]};
        return v;
    endfunction

    function automatic logic [7:0] wd(input int i);
        return {4'(i), wc[i]};
    endfunction

    initial begin
        // Single requester, 6 words: one self-regrant with no gap, then back to IDLE.
        tbl[0]  = '{1'b1, 4'b0001, 32'h0000_0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[1]  = '{1'b0, 4'b0001, 32'h0000_0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h01};
        tbl[2]  = '{1'b0, 4'b0001, 32'h0000_0002, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h02};
        tbl[3]  = '{1'b0, 4'b0001, 32'h0000_0003, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h03};
        tbl[4]  = '{1'b0, 4'b0001, 32'h0000_0004, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h04};
        tbl[5]  = '{1'b0, 4'b0001, 32'h0000_0005, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h05};
        tbl[6]  = '{1'b0, 4'b0001, 32'h0000_0006, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h06};
        tbl[7]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[8]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        // Withdrawal after 2 acks hands off to 2 with cnt cleared, so 2 gets a full 4-word burst.
        tbl[9]  = '{1'b1, 4'b0101, 32'h002A_0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[10] = '{1'b0, 4'b0101, 32'h002A_0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h01};
        tbl[11] = '{1'b0, 4'b0101, 32'h002A_0002, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h02};
        tbl[12] = '{1'b0, 4'b0100, 32'h002A_0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[13] = '{1'b0, 4'b0101, 32'h002A_0003, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h2A};
        tbl[14] = '{1'b0, 4'b0101, 32'h002B_0003, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h2B};
        tbl[15] = '{1'b0, 4'b0101, 32'h002C_0003, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h2C};
        tbl[16] = '{1'b0, 4'b0101, 32'h002D_0003, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h2D};
        tbl[17] = '{1'b0, 4'b0101, 32'h002E_0003, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h03};

        // Reset values are visible before any clock edge.
        rst_n = 1'b1; req = 4'b1111; req_data = 32'hA5A5_A5A5; fifo_full = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst0.owner_vld", 32'(owner_vld), 32'd0);
        check("rst0.fifo_wr", 32'(fifo_wr), 32'd0);
        check("rst0.ack", 32'(ack), 32'd0);
        check("rst0.fifo_din", 32'(fifo_din), 32'd0);
        check("rst0.owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) do_reset();
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].data, tbl[i].full, tbl[i].vld,
                 tbl[i].own, tbl[i].wr, tbl[i].ack, tbl[i].din);
        end

        // All four requesting: owners 0,1,2,3,0 with 4 words each and no write gap.
        do_reset();
        step("rr.c0", 4'b1111, pk(), 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        for (int c = 1; c <= 20; c++) begin
            automatic int eo = ((c - 1) / 4) % 4;
            step($sformatf("rr.c%0d", c), 4'b1111, pk(), 1'b0, 1'b1, 2'(eo), 1'b1, 4'(1 << eo), wd(eo));
            wc[eo]++;
        end

        // Full stall: owner 1 stalls 3 cycles after 2 acks, finishes 2 more, then hands off to 2.
        do_reset();
        step("stall.c0", 4'b0110, pk(), 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            automatic logic full = (c >= 3) && (c <= 5);
            automatic int   eo   = (c == 8) ? 2 : 1;
            step($sformatf("stall.c%0d", c), 4'b0110, pk(), full, 1'b1, 2'(eo), !full,
                 full ? 4'b0000 : 4'(1 << eo), wd(eo));
            if (!full) wc[eo]++;
        end

        // Reset mid-burst: requester 3 holds the grant when rst_n drops between edges.
        do_reset();
        step("mid.c0", 4'b1111, pk(), 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        for (int c = 1; c <= 14; c++) begin
            automatic int eo = ((c - 1) / 4) % 4;
            step($sformatf("mid.c%0d", c), 4'b1111, pk(), 1'b0, 1'b1, 2'(eo), 1'b1, 4'(1 << eo), wd(eo));
            wc[eo]++;
        end
        rst_n = 1'b0;
        #1;
        check("mid.rst.owner_vld", 32'(owner_vld), 32'd0);
        check("mid.rst.fifo_wr", 32'(fifo_wr), 32'd0);
        check("mid.rst.ack", 32'(ack), 32'd0);
        check("mid.rst.fifo_din", 32'(fifo_din), 32'd0);
        check("mid.rst.owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("mid.post0", 4'b1111, pk(), 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            automatic int eo = (c == 5) ? 1 : 0;
            step($sformatf("mid.post%0d", c), 4'b1111, pk(), 1'b0, 1'b1, 2'(eo), 1'b1, 4'(1 << eo), wd(eo));
            wc[eo]++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
